// File: rtl/envelope_gen_if.sv
// Control/status bundle for the ADSR envelope generator.
// master = upstream sequencer, slave = envelope_gen.
interface envelope_gen_if;
  logic       tick;
  logic       gate;
  logic [3:0] attack_rate;
  logic [3:0] decay_rate;
  logic [7:0] sustain_level;
  logic [3:0] release_rate;
  logic [7:0] env;
  logic [2:0] stage;
  logic       active;
  logic       done;

  modport master (
    output tick, gate, attack_rate, decay_rate, sustain_level, release_rate,
    input  env, stage, active, done
  );

  modport slave (
    input  tick, gate, attack_rate, decay_rate, sustain_level, release_rate,
    output env, stage, active, done
  );
endinterface

// File: rtl/envelope_gen.sv
// ADSR envelope generator: stage/amplitude advance once per tick strobe,
// with gate rising edges between ticks latched as a pending retrigger.
module envelope_gen (
  input  logic           clk,
  input  logic           nrst,
  envelope_gen_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } stage_e;

  stage_e      state_q, state_d;
  logic [7:0]  env_q, env_d;
  logic        done_q, done_d;
  logic        gate_q, pend_q;
  logic        rise;
  logic        legal;
  logic [8:0]  a_sum;
  logic signed [9:0] d_diff, r_diff, sus_s;

  assign rise   = bus.gate & ~gate_q;
  assign legal  = (state_q == IDLE) || (state_q == ATTACK) || (state_q == DECAY) ||
                  (state_q == SUSTAIN) || (state_q == RELEASE);
  // Wide signed intermediates so env - step can go negative without wrapping.
  assign a_sum  = {1'b0, env_q} + {5'd0, bus.attack_rate} + 9'd1;
  assign d_diff = $signed({2'b00, env_q}) - $signed({6'd0, bus.decay_rate}) - 10'sd1;
  assign r_diff = $signed({2'b00, env_q}) - $signed({6'd0, bus.release_rate}) - 10'sd1;
  assign sus_s  = $signed({2'b00, bus.sustain_level});

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    done_d  = 1'b0;
    if (bus.tick) begin
      if (!legal) begin
        state_d = IDLE;
        env_d   = 8'd0;
      end else if (pend_q || rise) begin
        state_d = ATTACK;
      end else if (!bus.gate && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
        state_d = RELEASE;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.gate) state_d = ATTACK;
            else          env_d   = 8'd0;
          end
          ATTACK: begin
            if (a_sum >= 9'd255) begin
              env_d   = 8'd255;
              state_d = DECAY;
            end else begin
              env_d   = a_sum[7:0];
            end
          end
          DECAY: begin
            if (d_diff <= sus_s) begin
              env_d   = bus.sustain_level;
              state_d = SUSTAIN;
            end else begin
              env_d   = d_diff[7:0];
            end
          end
          SUSTAIN: env_d = bus.sustain_level;
          RELEASE: begin
            if (bus.gate) begin
              state_d = ATTACK;
            end else if (r_diff <= 10'sd0) begin
              env_d   = 8'd0;
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              env_d   = r_diff[7:0];
            end
          end
          default: begin
            state_d = IDLE;
            env_d   = 8'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      env_q   <= 8'd0;
      done_q  <= 1'b0;
      gate_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      done_q  <= done_d;
      gate_q  <= bus.gate;
      // A tick always consumes the pending retrigger, including a coincident edge.
      pend_q  <= bus.tick ? 1'b0 : (pend_q | rise);
    end
  end

  assign bus.env    = env_q;
  assign bus.stage  = state_q;
  assign bus.active = (state_q != IDLE);
  assign bus.done   = done_q;
endmodule
